t1_retire_watchdog: RTL and testbench
=====================================

# t1_retire_watchdog

Synthesizable counterpart of the simulation-control loop: consumes the testbench clock/reset and produces the per-cycle status byte that sim control polls (0 = continue, 255 = quit successfully, other = fatal). Tracks outstanding vector instructions and enforces the inter-retire and global timeouts. Buffers retire events, each stamped with the cycle count, for the RTL event logger. Sits in the t1emu testbench top beside the DUT's issue/retire probes.

## Interface
Parameters:
- FIFO_DEPTH, 8, retire-event buffer entries; power of two, ≥2
- TAG_W, 8, retire tag width
- CNT_W, 8, outstanding-instruction counter width

Ports:
- clock  in  1  testbench clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  one vector instruction issued this cycle
- retire_valid  in  1  one vector instruction retired this cycle
- retire_tag  in  TAG_W  tag of the retiring instruction
- quit_req  in  1  testbench-side finish request; level, sampled each cycle
- timeout  in  64  max cycles without retire while outstanding > 0; 0 disables; static after reset
- global_timeout  in  64  max total cycles; 0 disables; static after reset
- evt_valid  out  1  event-buffer head valid
- evt_ready  in  1  logger accepts head
- evt_cycle  out  64  cycle stamp of head event
- evt_tag  out  TAG_W  tag of head event
- status  out  8  watchdog status code
- cycle  out  64  cycles since reset deassertion

## Operation
- Status codes: 0 RUNNING, 255 DONE, 1 RETIRE_TIMEOUT, 2 GLOBAL_TIMEOUT, 3 EVT_OVERFLOW, 4 CNT_UNDERFLOW, 5 CNT_OVERFLOW.
- FSM states: RUN, DRAIN, DONE, FAIL. Reset → RUN.
- RUN: quit_req=1 → DRAIN.
- DRAIN: outstanding==0 and buffer empty and no push this cycle → DONE. quit_req deassertion is ignored (no return to RUN).
- RUN/DRAIN: any error → FAIL with its code. Several errors in one cycle: lowest code wins.
- DONE, FAIL: terminal until reset; counters freeze; status holds; buffer still drains to the logger.
- Outstanding counter: +1 on issue, −1 on retire; issue and retire together → unchanged.
  - Retire at 0 without issue → code 4.
  - Issue at all-ones without retire → code 5.
- Retire-gap counter: cleared on retire; increments each cycle while outstanding>0; holds while outstanding==0. Reaching timeout (counter == timeout, timeout≠0) → code 1.
- cycle increments every cycle in RUN/DRAIN. cycle == global_timeout (≠0) → code 2.
- Each retire_valid pushes {cycle, retire_tag}. Push when full with no pop in that cycle → code 3, event dropped. Push and pop in the same cycle at full → legal, no overflow.
- Handshake: pop when evt_valid && evt_ready. evt_cycle/evt_tag stable while evt_valid && !evt_ready.

## Timing
- All outputs registered. Reset values: status=0, cycle=0, evt_valid=0, evt_cycle=0, evt_tag=0; internal counters 0, buffer empty.
- status reflects an event in the cycle after it is sampled; e.g. quit with everything idle at edge N → DONE visible after edge N+1.
- Push latency: evt_valid rises one cycle after retire_valid into an empty buffer. No bypass.
- Throughput: one push and one pop per cycle.
- evt_cycle equals the cycle value in the retire cycle, i.e. before that edge's increment.
- Reset assertion mid-operation clears all state immediately and asynchronously, including buffered events. Deassertion is used synchronized to clock.

## Structure
- t1_watchdog_pkg: status-code localparams/enum, FSM state enum, packed event struct {cycle[63:0], tag}.
- Sub-module t1_event_fifo:
  - parameterized synchronous FIFO with valid/ready output and full flag
  - registered head
  - pointer width $clog2(FIFO_DEPTH)+1 for the full/empty distinction
- Top holds the FSM, counters, and error priority.

## Test plan
- Normal finish, timeout=100: issue 3 instructions, retire them at cycles 10/11/12 with tags 1/2/3, logger always ready, then quit_req → events (10,1),(11,2),(12,3) delivered in order; status=255 one cycle after the buffer empties.
- Quit while busy: issue 2 instructions, quit_req at cycle 5, retires at 20 and 21 → status stays 0 through DRAIN; 255 appears after the last event pops.
- Retire timeout: timeout=50, one issue at cycle 0, no retire → status=1 at cycle 51; cycle frozen at 50.
- Global timeout: global_timeout=1000, no activity → status=2 one cycle after cycle reaches 1000. Separately, timeout=0 with an outstanding instruction never yields code 1.
- Overflow/backpressure: FIFO_DEPTH=4, evt_ready=0, 5 retires → status=3 on the fifth. A rerun with one pop coinciding with the fifth push → no error, 4 entries held.
- Counter errors and reset:
  - retire with outstanding=0 → status=4
  - 255 issues with CNT_W=8 then one more → status=5
  - reset asserted mid-DRAIN → all outputs return to reset values, FSM re-enters RUN

Source files
------------

// File: rtl/t1_watchdog_pkg.sv
// Shared types and status codes for the retire watchdog and its event buffer.
package t1_watchdog_pkg;

  localparam int unsigned CYCLE_W  = 64;
  localparam int unsigned T1_TAG_W = 8;

  localparam logic [7:0] ST_RUNNING         = 8'd0;
  localparam logic [7:0] ST_DONE            = 8'd255;
  localparam logic [7:0] ERR_RETIRE_TIMEOUT = 8'd1;
  localparam logic [7:0] ERR_GLOBAL_TIMEOUT = 8'd2;
  localparam logic [7:0] ERR_EVT_OVERFLOW   = 8'd3;
  localparam logic [7:0] ERR_CNT_UNDERFLOW  = 8'd4;
  localparam logic [7:0] ERR_CNT_OVERFLOW   = 8'd5;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CYCLE_W-1:0]  cycle;
    logic [T1_TAG_W-1:0] tag;
  } evt_t;

  // Error flags are ordered by code (bit 0 = code 1); the lowest code wins.
  function automatic logic [7:0] first_err(input logic [4:0] e);
    logic [7:0] c;
    c = ST_RUNNING;
    if (e[4]) c = ERR_CNT_OVERFLOW;
    if (e[3]) c = ERR_CNT_UNDERFLOW;
    if (e[2]) c = ERR_EVT_OVERFLOW;
    if (e[1]) c = ERR_GLOBAL_TIMEOUT;
    if (e[0]) c = ERR_RETIRE_TIMEOUT;
    return c;
  endfunction

endpackage

// File: rtl/t1_retire_watchdog_fifo.sv
// Retire-event buffer: synchronous FIFO with a registered head and valid/ready pop.
module t1_event_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full_c,
  output logic              o_pop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic              r_valid;
  logic [DATA_W-1:0] r_head;

  logic              w_full;
  logic              w_pop;
  logic              w_wr_en;
  logic [PW-1:0]     w_wr_next;
  logic [PW-1:0]     w_rd_next;
  logic [DATA_W-1:0] w_head_next;

  assign w_full    = (r_wr - r_rd) == PW'(DEPTH);
  assign w_pop     = r_valid && i_ready;
  // A push at full is accepted only when the head leaves in the same cycle.
  assign w_wr_en   = i_push && (!w_full || w_pop);
  assign w_wr_next = r_wr + PW'(w_wr_en);
  assign w_rd_next = r_rd + PW'(w_pop);

  // Next head comes from the array unless this cycle's write lands in the head slot.
  assign w_head_next = (w_wr_en && (r_wr[AW-1:0] == w_rd_next[AW-1:0])) ?
                       i_data : r_mem[w_rd_next[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      r_wr    <= w_wr_next;
      r_rd    <= w_rd_next;
      r_valid <= (w_wr_next != w_rd_next);
      r_head  <= w_head_next;
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_head;
  assign o_full_c = w_full;
  assign o_pop_c  = w_pop;

endmodule

// File: rtl/t1_retire_watchdog.sv
// Simulation-control watchdog: outstanding-instruction tracking, timeouts and retire-event logging.
module t1_retire_watchdog
  import t1_watchdog_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TAG_W      = T1_TAG_W,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               retire_valid,
  input  logic [TAG_W-1:0]   retire_tag,
  input  logic               quit_req,
  input  logic [63:0]        timeout,
  input  logic [63:0]        global_timeout,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [63:0]        evt_cycle,
  output logic [TAG_W-1:0]   evt_tag,
  output logic [7:0]         status,
  output logic [63:0]        cycle
);

  localparam int unsigned EVT_W = CYCLE_W + TAG_W;

  state_t             r_state;
  logic [7:0]         r_status;
  logic [CYCLE_W-1:0] r_cycle;
  logic [63:0]        r_gap;
  logic [CNT_W-1:0]   r_out;

  logic               w_active;
  logic               w_push;
  logic               w_full;
  logic               w_pop;
  logic [EVT_W-1:0]   w_head;
  logic [4:0]         w_err;
  logic [7:0]         w_code;
  logic [CNT_W-1:0]   w_out_next;
  logic [63:0]        w_gap_next;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_push   = w_active && retire_valid;

  t1_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk      (clock),
    .rst_n    (reset),
    .i_push   (w_push),
    .i_data   ({r_cycle, retire_tag}),
    .i_ready  (evt_ready),
    .o_valid  (evt_valid),
    .o_data   (w_head),
    .o_full_c (w_full),
    .o_pop_c  (w_pop)
  );

  assign evt_cycle = w_head[EVT_W-1 -: CYCLE_W];
  assign evt_tag   = w_head[TAG_W-1:0];

  always_comb begin
    w_out_next = r_out;
    case ({issue_valid, retire_valid})
      2'b10:   w_out_next = r_out + CNT_W'(1);
      2'b01:   w_out_next = r_out - CNT_W'(1);
      default: w_out_next = r_out;
    endcase
  end

  // Gap counts cycles since the last retire that end with work still outstanding.
  assign w_gap_next = retire_valid ? 64'd0 :
                      ((w_out_next != '0) ? (r_gap + 64'd1) : r_gap);

  assign w_err[0] = (timeout != 64'd0) && (r_gap == timeout);
  assign w_err[1] = (global_timeout != 64'd0) && (r_cycle == global_timeout);
  assign w_err[2] = retire_valid && w_full && !w_pop;
  assign w_err[3] = retire_valid && !issue_valid && (r_out == '0);
  assign w_err[4] = issue_valid && !retire_valid && (r_out == '1);
  assign w_code   = first_err(w_err);

  // Counters advance only in RUN/DRAIN; an error cycle freezes them where they stand.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RUN;
      r_status <= ST_RUNNING;
      r_cycle  <= '0;
      r_gap    <= '0;
      r_out    <= '0;
    end else begin
      case (r_state)
        S_RUN, S_DRAIN: begin
          if (w_err != 5'd0) begin
            r_state  <= S_FAIL;
            r_status <= w_code;
          end else begin
            r_out   <= w_out_next;
            r_gap   <= w_gap_next;
            r_cycle <= r_cycle + CYCLE_W'(1);
            if (r_state == S_RUN) begin
              if (quit_req) r_state <= S_DRAIN;
            end else if ((r_out == '0) && !evt_valid && !retire_valid) begin
              r_state  <= S_DONE;
              r_status <= ST_DONE;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign status = r_status;
  assign cycle  = r_cycle;

endmodule

// File: tb/tb_t1_retire_watchdog.sv
// Randomized and directed bench for t1_retire_watchdog against a queue-based behavioural model.
module tb_t1_retire_watchdog;

  localparam int DEPTH = 4;
  localparam int MAXC  = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        retire_valid = 1'b0;
  logic [7:0]  retire_tag = 8'd0;
  logic        quit_req = 1'b0;
  logic [63:0] timeout = 64'd0;
  logic [63:0] global_timeout = 64'd0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [63:0] evt_cycle;
  logic [7:0]  evt_tag;
  logic [7:0]  status;
  logic [63:0] cycle;

  t1_retire_watchdog #(.FIFO_DEPTH(DEPTH), .TAG_W(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .retire_valid(retire_valid),
    .retire_tag(retire_tag), .quit_req(quit_req), .timeout(timeout),
    .global_timeout(global_timeout), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_cycle(evt_cycle), .evt_tag(evt_tag), .status(status), .cycle(cycle)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: plain counters, a flag per phase and a queue for the buffer.
  int              m_out;
  longint unsigned m_gap;
  longint unsigned m_cycle;
  bit              m_quit;
  bit              m_done;
  int              m_code;
  longint unsigned q_cyc[$];
  int              q_tag[$];
  longint unsigned log_cyc[$];
  int              log_tag[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_status();
    if (m_code != 0) return m_code;
    if (m_done) return 255;
    return 0;
  endfunction

  task automatic model_clear();
    m_out = 0; m_gap = 0; m_cycle = 0; m_quit = 0; m_done = 0; m_code = 0;
    q_cyc.delete(); q_tag.delete(); log_cyc.delete(); log_tag.delete();
  endtask

  // Applies one clock edge's worth of the rules to the model, using the inputs driven now.
  task automatic model_edge();
    bit pop, act, was_empty, e1, e2, e3, e4, e5;
    int code, new_out;
    pop = (q_cyc.size() > 0) && evt_ready;
    act = !m_done && (m_code == 0);
    was_empty = (q_cyc.size() == 0);
    if (pop) begin
      void'(q_cyc.pop_front());
      void'(q_tag.pop_front());
    end
    if (act) begin
      e1 = (timeout != 0) && (m_gap == timeout);
      e2 = (global_timeout != 0) && (m_cycle == global_timeout);
      e3 = retire_valid && (q_cyc.size() + (pop ? 1 : 0) == DEPTH) && !pop;
      e4 = retire_valid && !issue_valid && (m_out == 0);
      e5 = issue_valid && !retire_valid && (m_out == MAXC);
      code = e1 ? 1 : e2 ? 2 : e3 ? 3 : e4 ? 4 : e5 ? 5 : 0;
      if (retire_valid && !e3) begin
        q_cyc.push_back(m_cycle);
        q_tag.push_back(int'(retire_tag));
      end
      if (code != 0) begin
        m_code = code;
      end else begin
        new_out = m_out + (issue_valid ? 1 : 0) - (retire_valid ? 1 : 0);
        if (!m_quit) begin
          if (quit_req) m_quit = 1;
        end else if (m_out == 0 && was_empty && !retire_valid) begin
          m_done = 1;
        end
        if (retire_valid) m_gap = 0;
        else if (new_out > 0) m_gap++;
        m_out = new_out;
        m_cycle++;
      end
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("status", {56'd0, status}, 64'(exp_status()));
      check("cycle", cycle, m_cycle);
      check("evt_valid", {63'd0, evt_valid}, {63'd0, q_cyc.size() > 0});
      if (q_cyc.size() > 0) begin
        check("evt_cycle", evt_cycle, q_cyc[0]);
        check("evt_tag", {56'd0, evt_tag}, 64'(q_tag[0]));
      end
      if (evt_valid && evt_ready) begin
        log_cyc.push_back(evt_cycle);
        log_tag.push_back(int'(evt_tag));
      end
    end
  end

  task automatic step(input bit iv, input bit rv, input int tag, input bit q, input bit rd, input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid = iv; retire_valid = rv; retire_tag = 8'(tag); quit_req = q; evt_ready = rd;
      @(posedge clock);
      model_edge();
      #2;
    end
  endtask

  task automatic do_reset(input longint unsigned to, input longint unsigned gto);
    chk_en = 0;
    reset = 0;
    issue_valid = 0; retire_valid = 0; retire_tag = 0; quit_req = 0; evt_ready = 0;
    timeout = to; global_timeout = gto;
    model_clear();
    repeat (2) @(posedge clock);
    #2;
    reset = 1;
    chk_en = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL sim_time_limit got 1 expected 0");
    $fatal(1, "time limit");
  end

  initial begin
    // Normal finish with in-order event delivery.
    do_reset(100, 0);
    check("reset_status", {56'd0, status}, 64'd0);
    check("reset_cycle", cycle, 64'd0);
    check("reset_evt_valid", {63'd0, evt_valid}, 64'd0);
    step(1, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 1, 7);
    for (int t = 1; t <= 3; t++) step(0, 1, t, 0, 1, 1);
    step(0, 0, 0, 1, 1, 5);
    check("normal_status", {56'd0, status}, 64'd255);
    check("normal_cycle", cycle, 64'd15);
    check("normal_log_n", 64'(log_cyc.size()), 64'd3);
    if (log_cyc.size() == 3) begin
      check("normal_ev0", (log_cyc[0] << 8) | 64'(log_tag[0]), (64'd10 << 8) | 64'd1);
      check("normal_ev1", (log_cyc[1] << 8) | 64'(log_tag[1]), (64'd11 << 8) | 64'd2);
      check("normal_ev2", (log_cyc[2] << 8) | 64'(log_tag[2]), (64'd12 << 8) | 64'd3);
    end

    // Retire timeout freezes the cycle counter where the gap hit the limit.
    do_reset(50, 0);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 60);
    check("rto_status", {56'd0, status}, 64'd1);
    check("rto_cycle", cycle, 64'd50);

    // Global timeout with no activity.
    do_reset(0, 1000);
    step(0, 0, 0, 0, 1, 1005);
    check("gto_status", {56'd0, status}, 64'd2);
    check("gto_cycle", cycle, 64'd1000);

    // timeout = 0 disables the retire watchdog.
    do_reset(0, 0);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 300);
    check("to0_status", {56'd0, status}, 64'd0);
    check("to0_cycle", cycle, 64'd301);

    // Overflow: fifth retire into a full, stalled buffer.
    do_reset(0, 0);
    step(1, 0, 0, 0, 0, 5);
    for (int t = 1; t <= 5; t++) step(0, 1, t, 0, 0, 1);
    check("ovf_status", {56'd0, status}, 64'd3);

    // Same, but a pop coincides with the fifth push.
    do_reset(0, 0);
    step(1, 0, 0, 0, 0, 5);
    for (int t = 1; t <= 4; t++) step(0, 1, t, 0, 0, 1);
    step(0, 1, 5, 0, 1, 1);
    step(0, 0, 0, 0, 0, 3);
    check("ovf_pop_status", {56'd0, status}, 64'd0);
    check("ovf_pop_head_cycle", evt_cycle, 64'd6);
    check("ovf_pop_head_tag", {56'd0, evt_tag}, 64'd2);
    check("ovf_pop_q", 64'(q_cyc.size()), 64'd4);

    // Underflow: retire with nothing outstanding.
    do_reset(0, 0);
    step(0, 1, 9, 0, 1, 1);
    step(0, 0, 0, 0, 1, 2);
    check("unf_status", {56'd0, status}, 64'd4);

    // Counter overflow: 255 issues fill it, the 256th errors.
    do_reset(0, 0);
    step(1, 0, 0, 0, 1, 256);
    step(0, 0, 0, 0, 1, 2);
    check("cof_status", {56'd0, status}, 64'd5);
    check("cof_cycle", cycle, 64'd255);

    // Reset asserted mid-DRAIN clears everything asynchronously.
    do_reset(0, 0);
    step(1, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 1, 0, 3);
    chk_en = 0;
    #1 reset = 0;
    #1;
    check("rst_mid_status", {56'd0, status}, 64'd0);
    check("rst_mid_cycle", cycle, 64'd0);
    check("rst_mid_evt_valid", {63'd0, evt_valid}, 64'd0);
    check("rst_mid_evt_cycle", evt_cycle, 64'd0);
    check("rst_mid_evt_tag", {56'd0, evt_tag}, 64'd0);

    // Quit while busy: stays 0 through DRAIN, 255 after the last pop.
    do_reset(0, 0);
    step(1, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 1, 15);
    step(0, 1, 7, 1, 1, 1);
    step(0, 1, 8, 1, 1, 1);
    step(0, 0, 0, 0, 1, 6);
    check("busy_status", {56'd0, status}, 64'd255);
    check("busy_cycle", cycle, 64'd24);

    // Randomized traffic against the model.
    for (int r = 0; r < 6; r++) begin
      do_reset(($urandom_range(0, 1) != 0) ? longint'($urandom_range(15, 40)) : 0,
               ($urandom_range(0, 1) != 0) ? longint'($urandom_range(150, 400)) : 0);
      for (int c = 0; c < 300; c++) begin
        bit iv, rv, q;
        iv = $urandom_range(0, 99) < 30;
        rv = ((m_out > 0) || ($urandom_range(0, 99) < 2)) && ($urandom_range(0, 99) < 35);
        q  = (c > 120) && ($urandom_range(0, 99) < 50);
        step(iv, rv, int'($urandom_range(0, 255)), q, $urandom_range(0, 99) < 60, 1);
      end
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
